// File: rtl/dip_event_queue.sv
// DIP switch change detector: turns level changes into {index, level}
// events and queues them in a small FWFT FIFO for the control FSM.
module dip_event_queue #(
  parameter int N_SW        = 8,
  parameter int IDX_W       = 3,
  parameter int DEPTH       = 4,
  parameter int REPORT_INIT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_SW-1:0]            dip_state,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [IDX_W-1:0]           evt_idx,
  output logic                       evt_level,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [N_SW-1:0]            pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [N_SW-1:0]  dip_prev;
  logic [N_SW-1:0]  rep;
  logic [N_SW-1:0]  pend;
  logic [IDX_W:0]   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] sel;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign pend  = (state_q == RUN) ? (dip_prev ^ rep) : '0;
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign pop   = !empty && evt_ready;
  assign push  = (state_q == RUN) && (|pend) && (!full || pop);

  // Fixed priority: scan downward so the lowest set bit wins.
  always_comb begin
    sel = '0;
    for (int k = N_SW - 1; k >= 0; k--) begin
      if (pend[k]) sel = IDX_W'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dip_prev <= '0;
      rep      <= '0;
    end else begin
      dip_prev <= dip_state;
      if (state_q == INIT) begin
        rep <= (REPORT_INIT != 0) ? '0 : dip_state;
      end else if (push) begin
        rep[sel] <= dip_prev[sel];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {sel, dip_prev[sel]};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign evt_valid  = !empty;
  assign evt_idx    = empty ? '0 : mem[rd_ptr][IDX_W:1];
  assign evt_level  = empty ? 1'b0 : mem[rd_ptr][0];
  assign fifo_count = count;
  assign pending    = pend;

endmodule

// File: tb/tb_dip_event_queue.sv
// Bench for dip_event_queue: queue-based reference model plus
// directed literal checks for both REPORT_INIT settings.
module tb_dip_event_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dip;
  logic       ready0;
  logic       ready1;

  logic       valid0, valid1;
  logic [2:0] idx0, idx1;
  logic       lvl0, lvl1;
  logic [2:0] cnt0, cnt1;
  logic [7:0] pend0, pend1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] log0[$];
  logic [3:0] log1[$];

  logic [7:0] m_prev;
  logic [7:0] m_rep;
  bit         m_run;
  logic [3:0] mq[$];

  always #5 clk = ~clk;

  dip_event_queue #(.REPORT_INIT(0)) u0 (
    .clk(clk), .rst(rst), .dip_state(dip),
    .evt_valid(valid0), .evt_ready(ready0),
    .evt_idx(idx0), .evt_level(lvl0),
    .fifo_count(cnt0), .pending(pend0)
  );

  dip_event_queue #(.REPORT_INIT(1)) u1 (
    .clk(clk), .rst(rst), .dip_state(dip),
    .evt_valid(valid1), .evt_ready(ready1),
    .evt_idx(idx1), .evt_level(lvl1),
    .fifo_count(cnt1), .pending(pend1)
  );

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: changed switches are reported lowest index first,
  // one per cycle, into a 4-entry queue; u0 only.
  initial begin
    m_prev = 0; m_rep = 0; m_run = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_prev = 0; m_rep = 0; m_run = 0;
        mq.delete();
      end else begin
        logic [7:0] pd;
        bit         pp;
        bit         ph;
        logic [3:0] ent;
        int         i;
        pd  = m_run ? (m_prev ^ m_rep) : 8'h00;
        pp  = (mq.size() != 0) && ready0;
        ph  = m_run && (pd != 0) && ((mq.size() < 4) || pp);
        ent = 4'h0;
        if (ph) begin
          i = 0;
          while (!pd[i]) i++;
          ent = {i[2:0], m_prev[i]};
          m_rep[i] = m_prev[i];
        end
        if (pp) void'(mq.pop_front());
        if (ph) mq.push_back(ent);
        if (!m_run) begin
          m_rep = dip;
          m_run = 1;
        end
        m_prev = dip;
      end
    end
  end

  initial begin
    forever begin
      logic [3:0] eh;
      bit         ev;
      @(negedge clk);
      ev = (mq.size() != 0);
      eh = ev ? mq[0] : 4'h0;
      check("valid", valid0, ev);
      check("idx", idx0, eh[3:1]);
      check("level", lvl0, eh[0]);
      check("count", cnt0, mq.size());
      check("pending", pend0, m_run ? (m_prev ^ m_rep) : 8'h00);
      if (valid0 && ready0) log0.push_back({idx0, lvl0});
      if (valid1 && ready1) log1.push_back({idx1, lvl1});
    end
  end

  initial begin
    logic [2:0] ex1 [4];
    ex1[0] = 3'd1; ex1[1] = 3'd3; ex1[2] = 3'd4; ex1[3] = 3'd6;
    rst = 1'b1; dip = 8'h5A; ready0 = 1'b1; ready1 = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check("ri1_pend_after_init", pend1, 8'h5A);
    check("ri1_valid_after_init", valid1, 0);
    check("ri0_pend_after_init", pend0, 8'h00);
    step();
    check("ri1_first_valid", valid1, 1);
    check("ri1_first_idx", idx1, 1);
    repeat (20) step();
    check("ri1_evt_count", log1.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < log1.size()) check("ri1_evt", log1[k], {ex1[k], 1'b1});
    end
    check("ri1_drained", cnt1, 0);
    check("ri0_quiet_valid", valid0, 0);
    check("ri0_quiet_count", cnt0, 0);

    dip = 8'h00;
    repeat (10) step();
    dip = 8'h81;
    step();
    check("s81_e0_valid", valid0, 0);
    check("s81_e0_pend", pend0, 8'h81);
    step();
    check("s81_e1_valid", valid0, 1);
    check("s81_e1_evt", {idx0, lvl0}, 4'b0001);
    check("s81_e1_pend", pend0, 8'h80);
    step();
    check("s81_e2_evt", {idx0, lvl0}, 4'b1111);
    step();
    check("s81_e3_count", cnt0, 0);

    dip = 8'h00;
    repeat (10) step();
    ready0 = 1'b0;
    dip = 8'hFF;
    repeat (7) step();
    check("full_count", cnt0, 4);
    check("full_pend", pend0, 8'hF0);
    check("full_head", {idx0, lvl0}, 4'b0001);
    log0.delete();
    dip = 8'hFB; step();
    dip = 8'hFF; step();
    dip = 8'hDF; step();
    dip = 8'hFF; step();
    ready0 = 1'b1;
    step();
    check("full_pushpop_count", cnt0, 4);
    check("full_pushpop_head", idx0, 1);
    check("full_pushpop_pend", pend0, 8'hE0);
    repeat (12) step();
    check("drain_evt_count", log0.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < log0.size()) check("drain_evt", log0[k], {3'(k), 1'b1});
    end
    check("drain_count", cnt0, 0);

    dip = 8'h00;
    repeat (14) step();
    ready0 = 1'b0;
    dip = 8'h07;
    repeat (5) step();
    dip = 8'h17;
    step();
    check("pre_rst_count", cnt0, 3);
    check("pre_rst_pend", pend0, 8'h10);
    rst = 1'b1;
    #1;
    check("async_rst_valid", valid0, 0);
    check("async_rst_count", cnt0, 0);
    check("async_rst_pend", pend0, 8'h00);
    step(); step();
    rst = 1'b0;
    ready0 = 1'b1;
    repeat (10) step();
    check("post_rst_valid", valid0, 0);

    repeat (400) begin
      if ($urandom % 4 == 0) dip = dip ^ 8'(1 << ($urandom % 8));
      if ($urandom % 16 == 0) dip = 8'($urandom);
      ready0 = ($urandom % 3) != 0;
      step();
    end
    ready0 = 1'b1;
    repeat (20) step();
    check("final_count", cnt0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
